scale_keypad_entry: RTL

Input front end for the electronic scale. Scans a 4x4 matrix keypad, debounces presses, and assembles a 4-digit BCD unit price. Emits single-cycle accumulate, clear-accumulate and clear strobes that drive the scale's button inputs directly. Sits between the board keypad pins and the scale core's `price`, `accumulate_btn`, `clear_accumulate_btn` and `clear_btn` inputs.

---
 rtl/scale_keypad_entry_pkg.sv | 74 +++++++
 rtl/scale_keypad_entry_if.sv | 31 +++
 rtl/scale_keypad_scan.sv | 153 +++++++++++++++
 rtl/scale_keypad_entry.sv | 92 +++++++++
 4 files changed

// File: rtl/scale_keypad_entry_pkg.sv
// Shared definitions for the scale keypad front end.
// Key codes are the raw matrix position row*4+col; the layout is
//   row0: 1 2 3 A / row1: 4 5 6 B / row2: 7 8 9 C / row3: * 0 # D
package scale_pkg;

  localparam int unsigned KP_LINES   = 4;
  localparam int unsigned KEY_W      = 4;
  localparam int unsigned PRICE_W    = 16;
  localparam int unsigned DCNT_W     = 3;
  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [KEY_W-1:0] KEY_1      = 4'd0;
  localparam logic [KEY_W-1:0] KEY_2      = 4'd1;
  localparam logic [KEY_W-1:0] KEY_3      = 4'd2;
  localparam logic [KEY_W-1:0] KEY_ACC    = 4'd3;
  localparam logic [KEY_W-1:0] KEY_4      = 4'd4;
  localparam logic [KEY_W-1:0] KEY_5      = 4'd5;
  localparam logic [KEY_W-1:0] KEY_6      = 4'd6;
  localparam logic [KEY_W-1:0] KEY_CLRACC = 4'd7;
  localparam logic [KEY_W-1:0] KEY_7      = 4'd8;
  localparam logic [KEY_W-1:0] KEY_8      = 4'd9;
  localparam logic [KEY_W-1:0] KEY_9      = 4'd10;
  localparam logic [KEY_W-1:0] KEY_CLR    = 4'd11;
  localparam logic [KEY_W-1:0] KEY_STAR   = 4'd12;
  localparam logic [KEY_W-1:0] KEY_0      = 4'd13;
  localparam logic [KEY_W-1:0] KEY_ENTER  = 4'd14;
  localparam logic [KEY_W-1:0] KEY_BKSP   = 4'd15;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } scan_state_t;

  // Accepted-key event handed from the scanner to the entry datapath
  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] code;
  } key_evt_t;

  // Matrix position to key code
  function automatic logic [KEY_W-1:0] key_code_f(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  function automatic logic key_is_digit(input logic [KEY_W-1:0] code);
    logic r;
    case (code)
      KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
      KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  // Key code to BCD digit value (0 for non-digit keys)
  function automatic logic [3:0] key_digit(input logic [KEY_W-1:0] code);
    logic [3:0] d;
    case (code)
      KEY_1:   d = 4'd1;
      KEY_2:   d = 4'd2;
      KEY_3:   d = 4'd3;
      KEY_4:   d = 4'd4;
      KEY_5:   d = 4'd5;
      KEY_6:   d = 4'd6;
      KEY_7:   d = 4'd7;
      KEY_8:   d = 4'd8;
      KEY_9:   d = 4'd9;
      default: d = 4'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/scale_keypad_entry_if.sv
// Keypad pins plus the price/command outputs toward the scale core.
//   master: the keypad entry block (drives col_n and all results)
//   slave : board/scale side (drives row_n)
interface scale_keypad_if;
  import scale_pkg::*;

  logic [KP_LINES-1:0] row_n;
  logic [KP_LINES-1:0] col_n;
  logic [PRICE_W-1:0]  price;
  logic [PRICE_W-1:0]  entry_value;
  logic [DCNT_W-1:0]   digit_cnt;
  logic                accumulate_btn;
  logic                clear_accumulate_btn;
  logic                clear_btn;
  logic                key_valid;
  logic [KEY_W-1:0]    key_code;

  modport master (
    input  row_n,
    output col_n, price, entry_value, digit_cnt,
    output accumulate_btn, clear_accumulate_btn, clear_btn,
    output key_valid, key_code
  );

  modport slave (
    output row_n,
    input  col_n, price, entry_value, digit_cnt,
    input  accumulate_btn, clear_accumulate_btn, clear_btn,
    input  key_valid, key_code
  );
endinterface

// File: rtl/scale_keypad_scan.sv
// Keypad scanner: row synchronizer, scan tick divider, scan/debounce FSM
// and column drive.
//   clk, rst   : clock, async active-high reset
//   row_n      : raw keypad rows (active low, asynchronous)
//   col_n      : one-hot-low column drive
//   key_valid  : registered one-cycle pulse per accepted key
//   key_code   : registered code of the last accepted key
//   evt_c      : accept event in the accepting tick cycle (combinational)
module scale_keypad_scan
  import scale_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 10000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KP_LINES-1:0] row_n,
  output logic [KP_LINES-1:0] col_n,
  output logic                key_valid,
  output logic [KEY_W-1:0]    key_code,
  output key_evt_t            evt_c
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV + 2);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 2);

  logic [KP_LINES-1:0] row_s1, row_s2;
  logic [DIV_W-1:0]    div_q;
  logic                tick;

  scan_state_t         state_q, state_d;
  logic [KP_LINES-1:0] col_q, col_d;
  logic [1:0]          row_q, row_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                key_valid_q;
  logic [KEY_W-1:0]    key_code_q;

  logic                any_low;
  logic [1:0]          low_row;
  logic [1:0]          col_idx;

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  // Free-running scan divider; tick period is SCAN_DIV+1 clocks
  assign tick = (div_q == DIV_W'(SCAN_DIV));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + DIV_W'(1);
  end

  // Lowest-index low row wins when several rows are pressed
  always_comb begin
    any_low = ~&row_s2;
    low_row = 2'd0;
    for (int i = KP_LINES - 1; i >= 0; i--) begin
      if (!row_s2[i]) low_row = 2'(i);
    end
  end

  always_comb begin
    col_idx = 2'd0;
    for (int i = 0; i < KP_LINES; i++) begin
      if (!col_q[i]) col_idx = 2'(i);
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Scan FSM next state; every decision is qualified by tick
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    evt_c      = '0;
    evt_c.code = key_code_f(row_q, col_idx);
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (any_low) begin
            row_d   = low_row;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = {col_q[KP_LINES-2:0], col_q[KP_LINES-1]};
          end
        end
        DEBOUNCE: begin
          if (any_low && (low_row == row_q)) begin
            if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
              evt_c.valid = 1'b1;
              cnt_d       = '0;
              state_d     = HOLD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = SCAN;
          end
        end
        HOLD: begin
          // Release must be stable for DEBOUNCE_SCANS ticks; no auto-repeat
          if (any_low) begin
            cnt_d = '0;
          end else if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
            cnt_d   = '0;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      col_q       <= 4'b1110;
      row_q       <= 2'd0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      key_valid_q <= evt_c.valid;
      if (evt_c.valid) key_code_q <= evt_c.code;
    end
  end

  assign col_n     = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: rtl/scale_keypad_entry.sv
// Keypad front end for the scale: scans the keypad and turns accepted keys
// into a 4-digit BCD price entry and one-cycle command strobes.
//   clk, rst : clock, async active-high reset
//   kp       : keypad pins, committed price, entry display, digit count,
//              accumulate / clear-accumulate / clear strobes, key_valid/key_code
module scale_keypad_entry
  import scale_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 10000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic           clk,
  input  logic           rst,
  scale_keypad_if.master kp
);

  key_evt_t           evt_c;
  logic [PRICE_W-1:0] price_q;
  logic [PRICE_W-1:0] entry_q;
  logic [DCNT_W-1:0]  cnt_q;
  logic               acc_q, clracc_q, clr_q;

  scale_keypad_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .row_n    (kp.row_n),
    .col_n    (kp.col_n),
    .key_valid(kp.key_valid),
    .key_code (kp.key_code),
    .evt_c    (evt_c)
  );

  // Entry datapath and strobe decode; updates land with key_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      price_q  <= '0;
      entry_q  <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      clracc_q <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      acc_q    <= 1'b0;
      clracc_q <= 1'b0;
      clr_q    <= 1'b0;
      if (evt_c.valid) begin
        case (evt_c.code)
          KEY_ACC:    acc_q    <= 1'b1;
          KEY_CLRACC: clracc_q <= 1'b1;
          KEY_CLR: begin
            clr_q   <= 1'b1;
            entry_q <= '0;
            cnt_q   <= '0;
          end
          KEY_BKSP: begin
            if (cnt_q != '0) begin
              entry_q <= entry_q >> 4;
              cnt_q   <= cnt_q - DCNT_W'(1);
            end
          end
          KEY_STAR: begin
            entry_q <= '0;
            cnt_q   <= '0;
          end
          KEY_ENTER: begin
            price_q <= entry_q;
            entry_q <= '0;
            cnt_q   <= '0;
          end
          default: begin
            // Digits beyond the fourth are dropped
            if (key_is_digit(evt_c.code) && (cnt_q < DCNT_W'(NUM_DIGITS))) begin
              entry_q <= {entry_q[PRICE_W-5:0], key_digit(evt_c.code)};
              cnt_q   <= cnt_q + DCNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign kp.price                = price_q;
  assign kp.entry_value          = entry_q;
  assign kp.digit_cnt            = cnt_q;
  assign kp.accumulate_btn       = acc_q;
  assign kp.clear_accumulate_btn = clracc_q;
  assign kp.clear_btn            = clr_q;

endmodule
